sobel_window_sched: RTL
=======================

# sobel_window_sched

Frame scheduler between `spi_control` and the Sobel kernel. It accepts the grayscale pixel stream in raster order and keeps two line buffers plus a 3x3 window. For every interior pixel position it issues one window to the Sobel core under a ready/done handshake, and it returns the resulting pixel to the SPI transmit path. It applies backpressure on the pixel stream while a window is in flight, and it marks the end of each frame.

## Interface
- `MAX_PIXEL_BITS`, 8 — pixel width (B), from `parameters.svh`
- `IMG_W`, 16 — frame width in pixels, ≥3
- `IMG_H`, 16 — frame height in pixels, ≥3
- `clk_i` in 1 — single clock
- `nreset_i` in 1 — asynchronous, active-low reset
- `frame_start_i` in 1 — starts a frame; sampled only in S_IDLE
- `px_valid_i` in 1 — gray pixel valid
- `px_gray_i` in B — gray pixel
- `px_ready_o` out 1 — pixel accepted when `px_valid_i & px_ready_o`
- `win_o` out 9·B — 3x3 window; pixel k = 3·row+col at `[k·B +: B]`; k=0 is top-left (oldest), k=8 is bottom-right (newest)
- `win_valid_o` out 1 — window offered to Sobel core
- `sobel_ready_i` in 1 — Sobel core takes window
- `sobel_done_i` in 1 — Sobel result valid
- `sobel_px_i` in B — Sobel result
- `px_sobel_o` out B — registered result, to SPI tx
- `px_sobel_valid_o` out 1 — one-cycle pulse with new `px_sobel_o`
- `frame_done_o` out 1 — one-cycle pulse after the last result of a frame
- `busy_o` out 1 — high in any state other than S_IDLE

## Operation
- **States**
  - S_IDLE: no pixels accepted.
  - S_ACCEPT: `px_ready_o`=1.
  - S_ISSUE: `win_valid_o`=1.
  - S_WAIT: waiting for the Sobel result.
- **Outputs are combinational from state:** `px_ready_o`, `win_valid_o`, `busy_o`.
- **S_IDLE → S_ACCEPT** on `frame_start_i`. The same cycle clears the row counter `row` and the column counter `col`. In all other states `frame_start_i` is ignored.
- **On pixel accept:**
  - Line buffer 0 (IMG_W-deep shift register) shifts in `px_gray_i`.
  - Line buffer 1 shifts in the output of line buffer 0.
  - The window shifts left one column. The new right column is (LB1 out, LB0 out, `px_gray_i`), from top to bottom.
  - `col`/`row` advance in raster order. `col` wraps from IMG_W-1 to 0 and increments `row`.
- **Window issue:** if the accepted pixel had `row`≥2 and `col`≥2, the state goes to S_ISSUE. Otherwise it stays in S_ACCEPT. This gives (IMG_W-2)·(IMG_H-2) windows per frame. Border pixels produce no output.
- **S_ISSUE → S_WAIT** when `sobel_ready_i`=1. `win_o` is stable from entry into S_ISSUE until the next pixel is accepted.
- **S_WAIT on `sobel_done_i`:**
  - `px_sobel_o` ← `sobel_px_i`, and `px_sobel_valid_o` pulses.
  - If that window came from pixel (IMG_H-1, IMG_W-1): `frame_done_o` pulses in the same cycle as `px_sobel_valid_o`, and the state goes to S_IDLE.
  - Otherwise the state goes to S_ACCEPT.
- **Handshake inputs outside their states:** `sobel_done_i` is ignored outside S_WAIT, and `sobel_ready_i` is ignored outside S_ISSUE.
- **Line buffer contents** are not cleared by `frame_start_i`. Windows that could contain stale data (`row`<2 or `col`<2) are never issued.
- **Reset** applies at any time, including mid-frame. Reset values:
  - state = S_IDLE, counters = 0, window = 0, line buffers = 0
  - `px_sobel_o` = 0
  - all valid/pulse outputs = 0
  - `px_ready_o` = 0, `busy_o` = 0
- **After reset,** the next frame needs `frame_start_i`. A partial frame is discarded without `frame_done_o`.

## Timing
- Pixel accepted at cycle N → `win_o` updated and `win_valid_o`=1 at N+1, if the window is complete.
- `sobel_ready_i` at cycle M → S_WAIT at M+1.
- `sobel_done_i` at cycle D → `px_sobel_valid_o` and `px_sobel_o` at D+1 → `px_ready_o`=1 at D+1.
- Best-case interior throughput with a zero-wait Sobel core: 1 result every 3 cycles.
- Border pixels: 1 pixel per cycle.
- `frame_start_i` at cycle S → `px_ready_o`=1 at S+1.
- Counter widths are `$clog2(IMG_W)` and `$clog2(IMG_H)`. Counters do not run past IMG_W-1 or IMG_H-1.

## Test plan
- **4x4 ramp frame, IMG_W=IMG_H=4:** pixels 0..15, `sobel_ready_i`=1, `sobel_done_i` one cycle after ready → exactly 4 windows.
  - The first window has k0..k8 = 0,1,2,4,5,6,8,9,10.
  - `frame_done_o` pulses with the 4th `px_sobel_valid_o`.
  - Then S_IDLE.
- **Backpressure:** hold `sobel_ready_i`=0 for 5 cycles at the first interior pixel → `win_valid_o` stays high, `win_o` is constant, `px_ready_o`=0 throughout, and no pixel is lost.
- **Sobel latency:** `sobel_done_i` arrives 7 cycles after the handshake, with `sobel_px_i`=8'hA5 → `px_sobel_o`=8'hA5 with a single pulse. Spurious `sobel_done_i` pulses in S_ACCEPT produce no output.
- **Minimum frame, 3x3:** exactly 1 window (pixels 0..8 in order) and 1 `frame_done_o`.
- **Reset mid-frame:** assert `nreset_i` while in S_WAIT → all outputs go to their reset values asynchronously. A following `frame_start_i` plus a full 4x4 frame produces correct windows.
- **`frame_start_i` outside S_IDLE:** pulsing it mid-frame has no effect on the counters or on the output count (still 4 results for 4x4).

Source files
------------

// File: rtl/sobel_window_sched.sv
// Raster pixel stream -> 3x3 windows for the Sobel core, one window in flight at a time; window 1 cycle after accept.
// Pixel input is stalled (px_ready_o=0) from an interior accept until its Sobel result returns.
module sobel_window_sched #(
  parameter int MAX_PIXEL_BITS = 8,
  parameter int IMG_W          = 16,
  parameter int IMG_H          = 16
) (
  input  logic                        clk_i,
  input  logic                        nreset_i,
  input  logic                        frame_start_i,
  input  logic                        px_valid_i,
  input  logic [MAX_PIXEL_BITS-1:0]   px_gray_i,
  output logic                        px_ready_o,
  output logic [9*MAX_PIXEL_BITS-1:0] win_o,
  output logic                        win_valid_o,
  input  logic                        sobel_ready_i,
  input  logic                        sobel_done_i,
  input  logic [MAX_PIXEL_BITS-1:0]   sobel_px_i,
  output logic [MAX_PIXEL_BITS-1:0]   px_sobel_o,
  output logic                        px_sobel_valid_o,
  output logic                        frame_done_o,
  output logic                        busy_o
);

  localparam int B  = MAX_PIXEL_BITS;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            last_q, last_d;
  logic [9*B-1:0]  win_q, win_d;
  logic [B-1:0]    px_sobel_q, px_sobel_d;
  logic            psv_q, psv_d;
  logic            fdone_q, fdone_d;
  logic [B-1:0]    lb0_q [IMG_W];
  logic [B-1:0]    lb1_q [IMG_W];
  logic [B-1:0]    lb0_out, lb1_out;
  logic            accept;

  assign lb0_out = lb0_q[IMG_W-1];
  assign lb1_out = lb1_q[IMG_W-1];
  assign accept  = (state_q == S_ACCEPT) && px_valid_i;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    last_d     = last_q;
    win_d      = win_q;
    px_sobel_d = px_sobel_q;
    psv_d      = 1'b0;
    fdone_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          state_d = S_ACCEPT;
          col_d   = '0;
          row_d   = '0;
          last_d  = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (px_valid_i) begin
          // Window slides left; the new right column is (2 lines ago, 1 line ago, now).
          for (int r = 0; r < 3; r++) begin
            win_d[(3*r)*B +: B]   = win_q[(3*r+1)*B +: B];
            win_d[(3*r+1)*B +: B] = win_q[(3*r+2)*B +: B];
          end
          win_d[2*B +: B] = lb1_out;
          win_d[5*B +: B] = lb0_out;
          win_d[8*B +: B] = px_gray_i;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (row_q >= RW'(2) && col_q >= CW'(2)) begin
            state_d = S_ISSUE;
            last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
          end
        end
      end
      S_ISSUE: begin
        if (sobel_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sobel_done_i) begin
          px_sobel_d = sobel_px_i;
          psv_d      = 1'b1;
          fdone_d    = last_q;
          state_d    = last_q ? S_IDLE : S_ACCEPT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      last_q     <= 1'b0;
      win_q      <= '0;
      px_sobel_q <= '0;
      psv_q      <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      last_q     <= last_d;
      win_q      <= win_d;
      px_sobel_q <= px_sobel_d;
      psv_q      <= psv_d;
      fdone_q    <= fdone_d;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else if (accept) begin
      lb0_q[0] <= px_gray_i;
      lb1_q[0] <= lb0_out;
      for (int i = 1; i < IMG_W; i++) begin
        lb0_q[i] <= lb0_q[i-1];
        lb1_q[i] <= lb1_q[i-1];
      end
    end
  end

  assign px_ready_o       = (state_q == S_ACCEPT);
  assign win_valid_o      = (state_q == S_ISSUE);
  assign busy_o           = (state_q != S_IDLE);
  assign win_o            = win_q;
  assign px_sobel_o       = px_sobel_q;
  assign px_sobel_valid_o = psv_q;
  assign frame_done_o     = fdone_q;

endmodule
